imem_fetch_unit: RTL and testbench

Parametrised successor to the single-port combinational instruction memory: a byte-addressed, big-endian instruction store with synchronous read, a small prefetch FIFO and a valid/ready handshake toward decode. It sits between the PC/branch logic and the decoder. It adds three things the earlier memory lacked: redirect/flush, fault reporting for misaligned or out-of-range fetches, and a byte-enabled program-load write port.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_fetch_unit_fifo.sv | 66 ++++++
 rtl/imem_fetch_unit.sv | 124 ++++++++++++
 tb/tb_imem_fetch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Purpose  : Shared types for the instruction fetch unit: the FIFO entry
//            layout and the fetch sequencer states.
// Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

  localparam int INSTR_W = 32;

  // One prefetched slot handed to decode; fault entries carry instr = 0.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic               fault;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/imem_fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small circular prefetch buffer with push, pop, flush, occupancy
//            count and a registered head entry.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import imem_pkg::*;
#(
  parameter int  FIFO_DEPTH = 2,
  parameter type T          = fetch_entry_t,
  localparam int PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  T              push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output T              head_o
);

  T              storage_q [FIFO_DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointers and occupancy; a flush moves the read pointer onto the write
  // pointer so a same-cycle push becomes the only (head) entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= wr_q;
      count_q <= push_i ? CW'(1) : '0;
      if (push_i) wr_q <= ptr_inc(wr_q);
    end else begin
      if (push_i) wr_q <= ptr_inc(wr_q);
      if (pop_i)  rd_q <= ptr_inc(rd_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; no reset needed because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_i && !reset) storage_q[wr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = storage_q[rd_q];

endmodule
`default_nettype wire

// File: rtl/imem_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_unit
// Purpose  : Big-endian byte-addressed instruction store with synchronous
//            read into a prefetch FIFO, redirect/flush, fault entries for
//            misaligned or out-of-range fetches and a byte-enabled load port.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int          DEPTH_BYTES = 256,
  parameter int          FIFO_DEPTH  = 2,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter              INIT_FILE   = "",
  localparam int         AW          = $clog2(DEPTH_BYTES),
  localparam int         WORDS       = DEPTH_BYTES / 4,
  localparam int         CW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  output logic               out_fault,
  input  logic               load_en,
  input  logic [AW-1:0]      load_addr,
  input  logic [31:0]        load_data,
  input  logic [3:0]         load_be
);

  // Image contents are delivered through the load port; the file name is
  // kept so existing instantiations still elaborate.
  localparam bit c_unused_init = (INIT_FILE != "");

  // Word-wide array with byte lanes; lane 3 holds the lowest byte address.
  logic [INSTR_W-1:0] mem_q [WORDS];

  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  fetch_pc_d;

  logic          w_pop;
  logic          w_space;
  logic          w_issue;
  logic          w_fault;
  logic [31:0]   w_addr;
  logic [31:0]   w_rd_word;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;
  logic          w_unused_load_lsb;

  assign w_unused_load_lsb = ^load_addr[1:0];

  // A redirect discards the same-cycle handshake and frees the whole FIFO.
  assign w_pop   = out_valid && out_ready && !redirect_valid;
  assign w_space = redirect_valid || (w_count < CW'(FIFO_DEPTH)) || w_pop;
  assign w_issue = !reset && ((state_q == RUN) || redirect_valid) && !load_en && w_space;
  assign w_addr  = redirect_valid ? redirect_pc : fetch_pc_q;
  assign w_fault = (w_addr[1:0] != 2'b00) || (w_addr > 32'(DEPTH_BYTES - 4));

  assign w_rd_word = mem_q[w_addr[AW-1:2]];

  // Build the entry for this cycle's issue; faults never read memory.
  always_comb begin
    w_push_entry    = '0;
    w_push_entry.pc = w_addr;
    if (w_fault) w_push_entry.fault = 1'b1;
    else         w_push_entry.instr = w_rd_word;
  end

  // Next fetch address: sequential after an issue, else follow a redirect.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (w_issue)             fetch_pc_d = w_addr + 32'd4;
    else if (redirect_valid) fetch_pc_d = redirect_pc;
  end

  // Fetch sequencer: halts once a fault entry is queued, resumes on redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      if (w_issue && w_fault)  state_q <= HALT;
      else if (redirect_valid) state_q <= RUN;
    end
  end

  // Program-load port: enabled byte lanes are written at the clock edge.
  always_ff @(posedge clk) begin
    if (load_en && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (load_be[b]) mem_q[load_addr[AW-1:2]][8*b +: 8] <= load_data[8*b +: 8];
      end
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .T          (fetch_entry_t)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (w_issue),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .flush_i     (redirect_valid),
    .count_o     (w_count),
    .head_o      (w_head)
  );

  assign out_valid = (w_count != '0);
  assign out_instr = out_valid ? w_head.instr : '0;
  assign out_pc    = out_valid ? w_head.pc    : '0;
  assign out_fault = out_valid ? w_head.fault : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_unit
// Purpose  : Directed stimulus with a scoreboard of accepted entries plus
//            cycle-exact checks of reset, backpressure, redirect, fault,
//            end-of-memory and load behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_unit;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic [3:0]  load_be;

  int total = 0;
  int bad   = 0;
  fetch_entry_t expq[$];

  always #5 clk = ~clk;

  imem_fetch_unit #(
    .DEPTH_BYTES (256),
    .FIFO_DEPTH  (2),
    .RESET_PC    (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_be        (load_be)
  );

  // Program image written through the load port.
  function automatic logic [31:0] img(input int a);
    case (a)
      0:       return 32'h006283B3;
      4:       return 32'h00838C63;
      40:      return 32'h00000000;
      default: return 32'hC0010000 | 32'(a);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic expect_e(input logic [31:0] pc, input logic [31:0] instr, input logic f);
    fetch_entry_t e;
    e.instr = instr;
    e.pc    = pc;
    e.fault = f;
    expq.push_back(e);
  endtask

  // Monitor: a handshake that completes at the next rising edge is compared
  // against the oldest expected entry.
  initial begin : monitor
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && out_valid && out_ready && !redirect_valid) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL accept: unexpected pc=%h instr=%h fault=%b", out_pc, out_instr, out_fault);
        end else begin
          e = expq.pop_front();
          if ({out_instr, out_pc, out_fault} !== e) begin
            bad++;
            $display("FAIL accept: got pc=%h instr=%h fault=%b want pc=%h instr=%h fault=%b",
                     out_pc, out_instr, out_fault, e.pc, e.instr, e.fault);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0; load_be = '0;
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc",    out_pc,    32'd0);
    chk("rst_fault", 32'(out_fault), 32'd0);

    // Load the whole image; load_en blocks every issue meanwhile.
    reset = 1'b0; load_en = 1'b1; load_be = 4'hF;
    for (int a = 0; a < 256; a += 4) begin
      load_addr = 8'(a);
      load_data = img(a);
      tick();
    end
    load_en = 1'b0; reset = 1'b1; out_ready = 1'b1;
    tick();
    tick();

    // Reset release: entries 0 and 4 stream out back to back.
    expect_e(32'd0, 32'h006283B3, 1'b0);
    expect_e(32'd4, 32'h00838C63, 1'b0);
    reset = 1'b0;
    chk("rel_empty", 32'(out_valid), 32'd0);
    tick();
    chk("rel_pc0",    out_pc,    32'd0);
    chk("rel_instr0", out_instr, 32'h006283B3);
    tick();
    chk("rel_pc4",    out_pc,    32'd4);
    chk("rel_instr4", out_instr, 32'h00838C63);
    tick();
    out_ready = 1'b0;

    // Backpressure: head holds pc 8 while 8 and 12 are buffered.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_pc",    out_pc,         32'd8);
    end
    chk("bp_instr", out_instr, img(8));

    // Redirect to 24 flushes 8/12; misaligned 26 faults and halts;
    // redirect to 0 resumes; 244 runs into the end of memory.
    expect_e(32'd24,  img(24),  1'b0);
    expect_e(32'd28,  img(28),  1'b0);
    expect_e(32'd26,  32'd0,    1'b1);
    expect_e(32'd0,   img(0),   1'b0);
    expect_e(32'd244, img(244), 1'b0);
    expect_e(32'd248, img(248), 1'b0);
    expect_e(32'd252, img(252), 1'b0);
    expect_e(32'd256, 32'd0,    1'b1);

    redirect_valid = 1'b1; redirect_pc = 32'd24; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("rd_valid", 32'(out_valid), 32'd1);
    chk("rd_pc",    out_pc,         32'd24);
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'd26;
    tick();
    redirect_valid = 1'b0;
    chk("mis_fault", 32'(out_fault), 32'd1);
    chk("mis_pc",    out_pc,         32'd26);
    chk("mis_instr", out_instr,      32'd0);
    tick();
    chk("halt_valid0", 32'(out_valid), 32'd0);
    tick();
    chk("halt_valid1", 32'(out_valid), 32'd0);
    chk("halt_pc",     out_pc,         32'd0);
    tick();
    chk("halt_valid2", 32'(out_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    tick();
    redirect_valid = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'd244;
    tick();
    redirect_valid = 1'b0;
    repeat (6) tick();
    chk("end_halt", 32'(out_valid), 32'd0);

    // Partial load at 40 together with a redirect to 36; no issue that cycle.
    expect_e(32'd36, img(36),       1'b0);
    expect_e(32'd40, 32'hDE00BE00,  1'b0);
    expect_e(32'd44, img(44),       1'b0);
    expect_e(32'd48, img(48),       1'b0);
    expect_e(32'd52, img(52),       1'b0);
    load_en = 1'b1; load_addr = 8'd40; load_data = 32'hDEADBEEF; load_be = 4'b1010;
    redirect_valid = 1'b1; redirect_pc = 32'd36; out_ready = 1'b0;
    tick();
    load_en = 1'b0; redirect_valid = 1'b0;
    chk("ld_stall", 32'(out_valid), 32'd0);
    tick();
    chk("ld_valid", 32'(out_valid), 32'd1);
    chk("ld_pc36",  out_pc,         32'd36);
    tick();
    tick();
    chk("ld_hold", out_pc, 32'd36);
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;

    // Mid-stream reset drops entries; redirect and load that cycle are ignored.
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd100;
    load_en = 1'b1; load_addr = 8'd0; load_data = 32'hFFFFFFFF; load_be = 4'hF;
    tick();
    reset = 1'b0; redirect_valid = 1'b0; load_en = 1'b0;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_pc",    out_pc,         32'd0);
    tick();
    chk("mrst_first_valid", 32'(out_valid), 32'd1);
    chk("mrst_first_pc",    out_pc,         32'd0);
    chk("mrst_first_instr", out_instr,      32'h006283B3);

    chk("sb_empty", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
